// File: rtl/event_unit_barrier_responder.sv
// Barrier responder: collects core arrivals against a participant mask and
// pulses barrier events to a target-core set, with register access on every port.
module event_unit_barrier_responder #(
    parameter int NB_CORES     = 4,
    parameter int PER_ID_WIDTH = NB_CORES + 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,

    input  logic                           periph_req_i,
    input  logic [31:0]                    periph_add_i,
    input  logic                           periph_wen_i,
    input  logic [31:0]                    periph_wdata_i,
    input  logic [PER_ID_WIDTH-1:0]        periph_id_i,
    output logic                           periph_gnt_o,
    output logic                           periph_r_valid_o,
    output logic [31:0]                    periph_r_rdata_o,
    output logic [PER_ID_WIDTH-1:0]        periph_r_id_o,

    input  logic [NB_CORES-1:0]            demux_req_i,
    input  logic [NB_CORES-1:0][31:0]      demux_add_i,
    input  logic [NB_CORES-1:0]            demux_wen_i,
    input  logic [NB_CORES-1:0][31:0]      demux_wdata_i,
    output logic [NB_CORES-1:0]            demux_gnt_o,
    output logic [NB_CORES-1:0]            demux_r_valid_o,
    output logic [NB_CORES-1:0][31:0]      demux_r_rdata_o,

    output logic [NB_CORES-1:0]            barrier_event_o,
    output logic [NB_CORES-1:0]            barrier_status_o
);

    localparam logic [2:0] REG_TRIG_MASK   = 3'd0;
    localparam logic [2:0] REG_STATUS      = 3'd1;
    localparam logic [2:0] REG_TARGET_MASK = 3'd2;
    localparam logic [2:0] REG_TRIGGER     = 3'd3;
    localparam logic [2:0] REG_MASK_STATUS = 3'd4;

    logic [NB_CORES-1:0] trig_mask_q, target_mask_q, status_q, status_d;
    logic [NB_CORES-1:0] arrivals;
    logic [NB_CORES-1:0] trig_mask_wdata, target_mask_wdata;
    logic                trig_mask_we, target_mask_we;
    logic                done;
    logic [31:0]         reg_val [8];
    logic [31:0]         periph_rdata_d;
    logic [NB_CORES-1:0][31:0] demux_rdata_d;
    logic                unused_bits;

    assign unused_bits = ^{periph_add_i, periph_wdata_i, demux_add_i, demux_wdata_i};

    assign periph_gnt_o     = periph_req_i;
    assign demux_gnt_o      = demux_req_i;
    assign barrier_status_o = status_q;

    always_comb begin
        for (int r = 0; r < 8; r++) begin
            reg_val[r] = '0;
        end
        reg_val[REG_TRIG_MASK]   = 32'(trig_mask_q);
        reg_val[REG_STATUS]      = 32'(status_q);
        reg_val[REG_TARGET_MASK] = 32'(target_mask_q);
        reg_val[REG_MASK_STATUS] = (32'(status_q) << 16) | 32'(trig_mask_q);
    end

    always_comb begin
        periph_rdata_d = '0;
        if (periph_req_i && periph_wen_i) begin
            periph_rdata_d = reg_val[periph_add_i[4:2]];
        end
        for (int i = 0; i < NB_CORES; i++) begin
            demux_rdata_d[i] = '0;
            if (demux_req_i[i] && demux_wen_i[i]) begin
                demux_rdata_d[i] = reg_val[demux_add_i[i][4:2]];
            end
        end
    end

    // Cores scanned highest-first, interconnect last, so the last assignment
    // gives interconnect > core 0 > core 1 ... priority on mask writes.
    always_comb begin
        arrivals          = '0;
        trig_mask_we      = 1'b0;
        trig_mask_wdata   = trig_mask_q;
        target_mask_we    = 1'b0;
        target_mask_wdata = target_mask_q;
        for (int i = NB_CORES - 1; i >= 0; i--) begin
            if (demux_req_i[i] && !demux_wen_i[i]) begin
                case (demux_add_i[i][4:2])
                    REG_TRIG_MASK: begin
                        trig_mask_we    = 1'b1;
                        trig_mask_wdata = demux_wdata_i[i][NB_CORES-1:0];
                    end
                    REG_TARGET_MASK: begin
                        target_mask_we    = 1'b1;
                        target_mask_wdata = demux_wdata_i[i][NB_CORES-1:0];
                    end
                    REG_TRIGGER: arrivals[i] = 1'b1;
                    default: ;
                endcase
            end
        end
        if (periph_req_i && !periph_wen_i) begin
            case (periph_add_i[4:2])
                REG_TRIG_MASK: begin
                    trig_mask_we    = 1'b1;
                    trig_mask_wdata = periph_wdata_i[NB_CORES-1:0];
                end
                REG_TARGET_MASK: begin
                    target_mask_we    = 1'b1;
                    target_mask_wdata = periph_wdata_i[NB_CORES-1:0];
                end
                REG_TRIGGER: arrivals = arrivals | periph_wdata_i[NB_CORES-1:0];
                default: ;
            endcase
        end
    end

    assign done = (trig_mask_q != '0) && ((status_q & trig_mask_q) == trig_mask_q) && !trig_mask_we;
    assign barrier_event_o = done ? target_mask_q : '0;

    // A completing episode restarts from the arrivals seen in the same cycle.
    always_comb begin
        status_d = status_q | arrivals;
        if (trig_mask_we) begin
            status_d = '0;
        end else if (done) begin
            status_d = arrivals;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trig_mask_q      <= '0;
            target_mask_q    <= '0;
            status_q         <= '0;
            periph_r_valid_o <= 1'b0;
            periph_r_rdata_o <= '0;
            periph_r_id_o    <= '0;
            demux_r_valid_o  <= '0;
            demux_r_rdata_o  <= '0;
        end else begin
            status_q <= status_d;
            if (trig_mask_we) begin
                trig_mask_q <= trig_mask_wdata;
            end
            if (target_mask_we) begin
                target_mask_q <= target_mask_wdata;
            end
            periph_r_valid_o <= periph_req_i;
            periph_r_rdata_o <= periph_rdata_d;
            if (periph_req_i) begin
                periph_r_id_o <= periph_id_i;
            end
            demux_r_valid_o <= demux_req_i;
            demux_r_rdata_o <= demux_rdata_d;
        end
    end

endmodule

// File: tb/tb_event_unit_barrier_responder.sv
// Bench for the barrier responder: directed scenarios plus random traffic,
// all checked every cycle against a transaction-level model.
module tb_event_unit_barrier_responder;

    localparam int NB  = 4;
    localparam int IDW = NB + 1;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 periph_req_i;
    logic [31:0]          periph_add_i;
    logic                 periph_wen_i;
    logic [31:0]          periph_wdata_i;
    logic [IDW-1:0]       periph_id_i;
    logic                 periph_gnt_o;
    logic                 periph_r_valid_o;
    logic [31:0]          periph_r_rdata_o;
    logic [IDW-1:0]       periph_r_id_o;
    logic [NB-1:0]        demux_req_i;
    logic [NB-1:0][31:0]  demux_add_i;
    logic [NB-1:0]        demux_wen_i;
    logic [NB-1:0][31:0]  demux_wdata_i;
    logic [NB-1:0]        demux_gnt_o;
    logic [NB-1:0]        demux_r_valid_o;
    logic [NB-1:0][31:0]  demux_r_rdata_o;
    logic [NB-1:0]        barrier_event_o;
    logic [NB-1:0]        barrier_status_o;

    event_unit_barrier_responder #(.NB_CORES(NB), .PER_ID_WIDTH(IDW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .periph_req_i(periph_req_i), .periph_add_i(periph_add_i), .periph_wen_i(periph_wen_i),
        .periph_wdata_i(periph_wdata_i), .periph_id_i(periph_id_i), .periph_gnt_o(periph_gnt_o),
        .periph_r_valid_o(periph_r_valid_o), .periph_r_rdata_o(periph_r_rdata_o),
        .periph_r_id_o(periph_r_id_o),
        .demux_req_i(demux_req_i), .demux_add_i(demux_add_i), .demux_wen_i(demux_wen_i),
        .demux_wdata_i(demux_wdata_i), .demux_gnt_o(demux_gnt_o),
        .demux_r_valid_o(demux_r_valid_o), .demux_r_rdata_o(demux_r_rdata_o),
        .barrier_event_o(barrier_event_o), .barrier_status_o(barrier_status_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [NB-1:0]  m_tm, m_tg, m_st;
    logic           e_pv;
    logic [31:0]    e_prd;
    logic [IDW-1:0] e_pid;
    logic [NB-1:0]  e_dv;
    logic [31:0]    e_drd [NB];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input int a);
        case (a)
            0: return 32'(m_tm);
            1: return 32'(m_st);
            2: return 32'(m_tg);
            4: return (32'(m_st) << 16) | 32'(m_tm);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_tm = '0; m_tg = '0; m_st = '0;
        e_pv = 1'b0; e_prd = '0; e_pid = '0; e_dv = '0;
        for (int i = 0; i < NB; i++) e_drd[i] = '0;
    endtask

    function automatic logic [31:0] mk_addr(input int r);
        logic [31:0] a;
        a = $urandom;
        a[4:2] = 3'(r);
        a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic idle();
        periph_req_i = 1'b0; periph_add_i = '0; periph_wen_i = 1'b1;
        periph_wdata_i = '0; periph_id_i = '0;
        demux_req_i = '0; demux_add_i = '0; demux_wen_i = '1; demux_wdata_i = '0;
    endtask

    task automatic p_wr(input int r, input logic [31:0] d);
        periph_req_i = 1'b1; periph_add_i = mk_addr(r); periph_wen_i = 1'b0;
        periph_wdata_i = d; periph_id_i = IDW'($urandom);
    endtask

    task automatic p_rd(input int r, input logic [IDW-1:0] id);
        periph_req_i = 1'b1; periph_add_i = mk_addr(r); periph_wen_i = 1'b1;
        periph_wdata_i = $urandom; periph_id_i = id;
    endtask

    task automatic c_wr(input int c, input int r, input logic [31:0] d);
        demux_req_i[c] = 1'b1; demux_add_i[c] = mk_addr(r);
        demux_wen_i[c] = 1'b0; demux_wdata_i[c] = d;
    endtask

    task automatic c_rd(input int c, input int r);
        demux_req_i[c] = 1'b1; demux_add_i[c] = mk_addr(r);
        demux_wen_i[c] = 1'b1; demux_wdata_i[c] = $urandom;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance it.
    task automatic tick();
        logic [NB-1:0] arr, tm_n, tg_n, ev;
        bit tm_w, tg_w, done;
        int pa;
        @(negedge clk_i);
        arr = '0; tm_w = 0; tg_w = 0; tm_n = m_tm; tg_n = m_tg;
        pa = int'(periph_add_i[4:2]);
        // writers in priority order: interconnect, then core 0 upward
        if (periph_req_i && !periph_wen_i) begin
            if (pa == 0) begin tm_w = 1; tm_n = periph_wdata_i[NB-1:0]; end
            if (pa == 2) begin tg_w = 1; tg_n = periph_wdata_i[NB-1:0]; end
            if (pa == 3) arr = arr | periph_wdata_i[NB-1:0];
        end
        for (int i = 0; i < NB; i++) begin
            if (demux_req_i[i] && !demux_wen_i[i]) begin
                case (int'(demux_add_i[i][4:2]))
                    0: if (!tm_w) begin tm_w = 1; tm_n = demux_wdata_i[i][NB-1:0]; end
                    2: if (!tg_w) begin tg_w = 1; tg_n = demux_wdata_i[i][NB-1:0]; end
                    3: arr[i] = 1'b1;
                    default: ;
                endcase
            end
        end
        done = (m_tm != 0) && ((m_st & m_tm) == m_tm) && !tm_w;
        ev = done ? m_tg : '0;

        check("status", 32'(barrier_status_o), 32'(m_st));
        check("event", 32'(barrier_event_o), 32'(ev));
        check("p_gnt", 32'(periph_gnt_o), 32'(periph_req_i));
        check("d_gnt", 32'(demux_gnt_o), 32'(demux_req_i));
        check("p_rvalid", 32'(periph_r_valid_o), 32'(e_pv));
        check("p_rdata", periph_r_rdata_o, e_prd);
        if (e_pv) check("p_rid", 32'(periph_r_id_o), 32'(e_pid));
        check("d_rvalid", 32'(demux_r_valid_o), 32'(e_dv));
        for (int i = 0; i < NB; i++) check($sformatf("d_rdata%0d", i), demux_r_rdata_o[i], e_drd[i]);

        e_pv  = periph_req_i;
        e_prd = (periph_req_i && periph_wen_i) ? model_read(pa) : 32'h0;
        if (periph_req_i) e_pid = periph_id_i;
        for (int i = 0; i < NB; i++) begin
            e_dv[i]  = demux_req_i[i];
            e_drd[i] = (demux_req_i[i] && demux_wen_i[i]) ? model_read(int'(demux_add_i[i][4:2])) : 32'h0;
        end
        if (tm_w)      m_st = '0;
        else if (done) m_st = arr;
        else           m_st = m_st | arr;
        m_tm = tm_n;
        m_tg = tg_n;
        @(posedge clk_i);
        #1;
    endtask

    task automatic rand_cycle();
        int op;
        idle();
        if ($urandom_range(0, 1) == 1) begin
            op = $urandom_range(0, 11);
            if (op < 4)       p_rd($urandom_range(0, 7), IDW'($urandom));
            else if (op < 8)  p_wr(3, $urandom);
            else if (op == 8) p_wr(0, $urandom);
            else if (op == 9) p_wr(2, $urandom);
            else              p_wr($urandom_range(4, 7), $urandom);
        end
        for (int c = 0; c < NB; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                op = $urandom_range(0, 11);
                if (op < 3)       c_rd(c, $urandom_range(0, 7));
                else if (op < 8)  c_wr(c, 3, $urandom);
                else if (op == 8) c_wr(c, 0, $urandom);
                else if (op == 9) c_wr(c, 2, $urandom);
                else              c_wr(c, $urandom_range(4, 7), $urandom);
            end
        end
    endtask

    initial begin
        idle();
        model_reset();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_pvalid", 32'(periph_r_valid_o), 32'h0);
        check("rst_event", 32'(barrier_event_o), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // 1: read STATUS with id 0x1A
        p_rd(1, IDW'(5'h1A));
        tick();
        idle();
        check("t1_rid", 32'(periph_r_id_o), 32'h1A);
        tick();

        // 2: sequential arrivals of all four cores
        p_wr(0, 32'hF); tick();
        p_wr(2, 32'h5); tick();
        idle();
        for (int c = 0; c < NB; c++) begin
            idle(); c_wr(c, 3, $urandom); tick();
        end
        idle();
        check("t2_event", 32'(barrier_event_o), 32'h5);
        tick();
        check("t2_event_off", 32'(barrier_event_o), 32'h0);
        check("t2_status", 32'(barrier_status_o), 32'h0);

        // 3: simultaneous arrivals, then an arrival during the pulse
        p_wr(0, 32'h6); tick();
        idle(); c_wr(1, 3, 0); c_wr(2, 3, 0); tick();
        idle(); c_wr(0, 3, 0);
        check("t3_event", 32'(barrier_event_o), 32'h5);
        tick();
        idle(); tick();
        check("t3_status", 32'(barrier_status_o), 32'h1);

        // 4: competing TRIG_MASK writes with a discarded arrival
        p_wr(0, 32'h3); c_wr(2, 0, 32'hC); c_wr(1, 3, 0); tick();
        idle(); p_rd(0, '0); tick();
        idle();
        check("t4_status", 32'(barrier_status_o), 32'h0);
        check("t4_mask", periph_r_rdata_o, 32'h3);
        tick();

        // 5: combined mask/status read and reserved registers
        p_wr(0, 32'hF); tick();
        idle(); c_wr(0, 3, 0); c_wr(3, 3, 0); tick();
        idle(); c_rd(2, 4); tick();
        idle(); c_rd(0, 5); c_rd(1, 6); c_rd(3, 7);
        check("t5_reg4", demux_r_rdata_o[2], 32'h0009000F);
        tick();
        idle(); tick();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            rand_cycle();
            tick();
        end

        // 6: reset lands while a read response is pending
        idle(); p_wr(0, 32'hA); c_wr(1, 2, 32'h7); tick();
        idle(); p_rd(0, IDW'(5'h11)); c_rd(3, 2); tick();
        idle();
        check("t6_pending", 32'(periph_r_valid_o), 32'h1);
        rst_ni = 1'b0;
        #1;
        check("t6_pvalid", 32'(periph_r_valid_o), 32'h0);
        check("t6_dvalid", 32'(demux_r_valid_o), 32'h0);
        check("t6_prdata", periph_r_rdata_o, 32'h0);
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        p_rd(0, '0); c_rd(0, 2); c_rd(1, 1); c_rd(2, 4); tick();
        idle(); tick();
        for (int n = 0; n < 100; n++) begin
            rand_cycle();
            tick();
        end
        idle(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
